// File: rtl/route_pkg.sv
// Shared types and constants for the route sequencer: action codes, the
// STOP direction code, the controller state encoding and direction levels.
package route_pkg;

  typedef enum logic [1:0] {
    ACT_CONTINUE = 2'b00,
    ACT_REVERSE  = 2'b01,
    ACT_PAUSE    = 2'b10,
    ACT_HALT     = 2'b11
  } action_t;

  localparam logic [3:0] DIR_STOP = 4'b1111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLANK   = 3'd1,
    RUN     = 3'd2,
    QUALIFY = 3'd3,
    DWELL   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic FORWARDS  = 1'b1;
  localparam logic BACKWARDS = 1'b0;

  // Largest of three counts; sizes the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/route_sequencer_cycle_timer.sv
// cycle_timer: loadable down-counter that stops at zero. expire is high
// while the count sits at zero, so a phase loaded with N-1 lasts N cycles.
module cycle_timer
  import route_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/route_sequencer.sv
// route_sequencer: mission controller. Qualifies STOP codes on DIR into
// events and, at each event, runs the next route-table action (continue,
// reverse, pause, halt) while gating the motors for a dwell period.
// Build option: define ROUTE_LOOP_EN to wrap the route back to entry 0
// after the last entry instead of finishing in DONE.
//
// cfg_we is a single-cycle write strobe with no back-pressure: a write is
// committed at the edge where cfg_we is high only if the controller is in
// IDLE or DONE and abort is low; otherwise it is dropped without notice.
module route_sequencer
  import route_pkg::*;
#(
  parameter int ROUTE_LEN    = 8,
  parameter int STOP_QUAL    = 3_000,
  parameter int STOP_DWELL   = 15_000,
  parameter int PAUSE_DWELL  = 60_000,
  parameter int RESUME_BLANK = 30_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [3:0]                   DIR,
  input  logic                         cfg_we,
  input  logic [$clog2(ROUTE_LEN)-1:0] cfg_addr,
  input  logic [1:0]                   cfg_data,
  output logic                         Direction,
  output logic                         motor_en,
  output logic [$clog2(ROUTE_LEN)-1:0] step_idx,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   dbg_state
);

  localparam int IW   = $clog2(ROUTE_LEN);
  localparam int MAXC = max3(RESUME_BLANK, STOP_QUAL, STOP_DWELL + PAUSE_DWELL);
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Timer load values are count-1 because the terminal cycle is the zero
  // count. The qualify load is count-2 because the RUN cycle that first
  // sees STOP already counts as the first qualifying cycle (STOP_QUAL >= 2).
  localparam logic [TW-1:0] LD_BLANK = TW'(RESUME_BLANK - 1);
  localparam logic [TW-1:0] LD_QUAL  = TW'(STOP_QUAL - 2);
  localparam logic [TW-1:0] LD_DWELL = TW'(STOP_DWELL - 1);
  localparam logic [TW-1:0] LD_PAUSE = TW'(STOP_DWELL + PAUSE_DWELL - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROUTE_LEN - 1);

`ifdef ROUTE_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  state_t          state_q, state_d;
  action_t         act_q, act_d;
  logic            dir_d, men_d, busy_d, done_d;
  logic [IW-1:0]   idx_d;
  logic [1:0]      tbl [ROUTE_LEN];
  logic            tmr_load, tmr_en, tmr_exp;
  logic [TW-1:0]   tmr_val;
  logic            cfg_ok;

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  assign cfg_ok    = cfg_we && !abort && ((state_q == IDLE) || (state_q == DONE));
  assign busy_d    = (state_d == BLANK) || (state_d == RUN) ||
                     (state_d == QUALIFY) || (state_d == DWELL);
  assign done_d    = (state_d == DONE);
  assign dbg_state = state_q;

  // Route table: cleared by reset, kept across abort, writable only when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROUTE_LEN; i++) tbl[i] <= ACT_CONTINUE;
    end else if (cfg_ok) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // State and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      act_q     <= ACT_CONTINUE;
      Direction <= FORWARDS;
      motor_en  <= 1'b0;
      step_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      Direction <= dir_d;
      motor_en  <= men_d;
      step_idx  <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state, next-output and timer control for the sequencer.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    dir_d    = Direction;
    men_d    = motor_en;
    idx_d    = step_idx;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = LD_BLANK;

    if (abort) begin
      state_d = IDLE;
      dir_d   = FORWARDS;
      men_d   = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = BLANK;
            dir_d    = FORWARDS;
            men_d    = 1'b1;
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = LD_BLANK;
          end
        end
        BLANK: begin
          if (tmr_exp) state_d = RUN;
          else         tmr_en  = 1'b1;
        end
        RUN: begin
          if (DIR == DIR_STOP) begin
            state_d  = QUALIFY;
            tmr_load = 1'b1;
            tmr_val  = LD_QUAL;
          end
        end
        QUALIFY: begin
          if (DIR != DIR_STOP) begin
            state_d = RUN;
          end else if (tmr_exp) begin
            state_d  = DWELL;
            men_d    = 1'b0;
            act_d    = action_t'(tbl[step_idx]);
            tmr_load = 1'b1;
            tmr_val  = (act_d == ACT_PAUSE) ? LD_PAUSE : LD_DWELL;
          end else begin
            tmr_en = 1'b1;
          end
        end
        DWELL: begin
          if (!tmr_exp) begin
            tmr_en = 1'b1;
          end else if (act_q == ACT_HALT) begin
            state_d = DONE;
          end else begin
            if (act_q == ACT_REVERSE) dir_d = ~Direction;
            idx_d = step_idx + IW'(1);
            if ((step_idx == LAST_IDX) && !LOOP_EN) begin
              state_d = DONE;
            end else begin
              state_d  = BLANK;
              men_d    = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = LD_BLANK;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_route_sequencer.sv
// Bench for route_sequencer with a short route (4 entries) and short timings.
module tb_route_sequencer;
  import route_pkg::*;

  localparam int         W    = 12;
  localparam logic [3:0] PROC = 4'b0110;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, cfg_we;
  logic [3:0] DIR;
  logic [1:0] cfg_addr, cfg_data;
  logic       Direction, motor_en, busy, done;
  logic [1:0] step_idx;
  logic [2:0] dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected dwell events: {dwell length[7:0], done, Direction, step_idx}.
  logic [W-1:0] exp_q[$];

  route_sequencer #(
    .ROUTE_LEN(4), .STOP_QUAL(4), .STOP_DWELL(10), .PAUSE_DWELL(5), .RESUME_BLANK(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .DIR(DIR),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .Direction(Direction), .motor_en(motor_en), .step_idx(step_idx),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ev(input int len, input logic d, input logic dir, input int idx);
    return {len[7:0], d, dir, idx[1:0]};
  endfunction

  // Scoreboard monitor: measures each dwell and compares at its end.
  int   dw_cnt     = 0;
  logic in_dw_prev = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] obs, e;
    if (!rst_n) begin
      dw_cnt     = 0;
      in_dw_prev = 1'b0;
    end else begin
      if (busy && !motor_en) begin
        dw_cnt++;
      end else if (in_dw_prev) begin
        if (busy || done) begin
          obs = {dw_cnt[7:0], done, Direction, step_idx};
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL dwell_event: unexpected dwell len=%0d done=%0d dir=%0d idx=%0d, required none",
                     obs[11:4], obs[3], obs[2], obs[1:0]);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
              tests_failed++;
              $display("FAIL dwell_event: got len=%0d done=%0d dir=%0d idx=%0d, required len=%0d done=%0d dir=%0d idx=%0d",
                       obs[11:4], obs[3], obs[2], obs[1:0], e[11:4], e[3], e[2], e[1:0]);
            end
          end
        end
        dw_cnt = 0;
      end
      in_dw_prev = busy && !motor_en;
    end
  end

  // Driver tasks
  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (dbg_state !== s && n < 300) begin @(negedge clk); n++; end
    if (dbg_state !== s) begin
      tests_run++; tests_failed++;
      $display("FAIL %s_timeout: state=%0d, required %0d", tag, dbg_state, s);
    end
  endtask

  task automatic wait_dwell_end();
    int n = 0;
    while (busy && !motor_en && n < 200) begin @(negedge clk); n++; end
    if (busy && !motor_en) begin
      tests_run++; tests_failed++;
      $display("FAIL dwell_timeout: motor_en=%0d after %0d cycles, required dwell end", motor_en, n);
    end
  endtask

  task automatic do_event();
    wait_state(RUN, "run");
    DIR = DIR_STOP;
    repeat (4) @(negedge clk);
    DIR = PROC;
    wait_dwell_end();
  endtask

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic write_cfg(input logic [1:0] a, input logic [1:0] d);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic push_crph();
    exp_q.push_back(ev(10, 1'b0, 1'b1, 1));
    exp_q.push_back(ev(10, 1'b0, 1'b0, 2));
    exp_q.push_back(ev(15, 1'b0, 1'b0, 3));
    exp_q.push_back(ev(10, 1'b1, 1'b0, 3));
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({Direction, motor_en, step_idx, busy, done} !== 6'b1_0_00_0_0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got dir=%0d men=%0d idx=%0d busy=%0d done=%0d, required 1 0 0 0 0",
               Direction, motor_en, step_idx, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dbg_state !== 3'(IDLE) || motor_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got state=%0d men=%0d, required state=0 men=0", dbg_state, motor_en);
    end
  endtask

  task automatic test_held_stop();
    int cnt = 0;
    DIR = DIR_STOP;
    start_run();
    while (motor_en === 1'b1 && cnt < 50) begin cnt++; @(negedge clk); end
    tests_run++;
    if (cnt != 10) begin
      tests_failed++;
      $display("FAIL held_stop_latency: motor_en high for %0d cycles, required 10", cnt);
    end
    exp_q.push_back(ev(10, 1'b0, 1'b1, 1));
    DIR = PROC;
    wait_dwell_end();
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL held_stop_events: %0d expected events left, required 0", exp_q.size());
    end
    exp_q.delete();
    do_abort();
  endtask

  task automatic test_glitch();
    start_run();
    wait_state(RUN, "glitch_run");
    DIR = DIR_STOP;
    repeat (3) @(negedge clk);
    DIR = PROC;
    repeat (20) begin
      @(negedge clk);
      tests_run++;
      if (motor_en !== 1'b1 || step_idx !== 2'd0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL glitch_no_event: got men=%0d idx=%0d busy=%0d, required 1 0 1", motor_en, step_idx, busy);
      end
    end
    do_abort();
  endtask

  task automatic test_route();
    push_crph();
    start_run();
    repeat (4) do_event();
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || step_idx !== 2'd3 || motor_en !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL route_done: got done=%0d idx=%0d men=%0d busy=%0d, required 1 3 0 0", done, step_idx, motor_en, busy);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL route_events: %0d expected events left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_abort();
    exp_q.push_back(ev(10, 1'b0, 1'b1, 1));
    exp_q.push_back(ev(10, 1'b0, 1'b0, 2));
    start_run();
    repeat (2) do_event();
    wait_state(RUN, "abort_run");
    DIR = DIR_STOP;
    repeat (4) @(negedge clk);
    DIR = PROC;
    repeat (3) @(negedge clk);
    do_abort();
    tests_run++;
    if ({dbg_state, Direction, motor_en, step_idx, busy, done} !== {3'(IDLE), 6'b1_0_00_0_0}) begin
      tests_failed++;
      $display("FAIL abort_idle: got state=%0d dir=%0d men=%0d idx=%0d busy=%0d done=%0d, required 0 1 0 0 0 0",
               dbg_state, Direction, motor_en, step_idx, busy, done);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_events: %0d expected events left, required 0", exp_q.size());
    end
    exp_q.delete();
    push_crph();
    start_run();
    repeat (4) do_event();
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || step_idx !== 2'd3 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_readback: got done=%0d idx=%0d left=%0d, required 1 3 0", done, step_idx, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_cfg_lockout();
    push_crph();
    start_run();
    wait_state(RUN, "cfg_run");
    write_cfg(2'd2, ACT_HALT);
    repeat (4) do_event();
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || step_idx !== 2'd3 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL cfg_ignored_in_run: got done=%0d idx=%0d left=%0d, required 1 3 0", done, step_idx, exp_q.size());
    end
    exp_q.delete();
    write_cfg(2'd2, ACT_HALT);
    exp_q.push_back(ev(10, 1'b0, 1'b1, 1));
    exp_q.push_back(ev(10, 1'b0, 1'b0, 2));
    exp_q.push_back(ev(10, 1'b1, 1'b0, 2));
    start_run();
    repeat (3) do_event();
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || step_idx !== 2'd2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL cfg_applied_in_done: got done=%0d idx=%0d left=%0d, required 1 2 0", done, step_idx, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_all_continue();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({Direction, motor_en, step_idx, busy, done} !== 6'b1_0_00_0_0) begin
      tests_failed++;
      $display("FAIL rereset_outputs: got dir=%0d men=%0d idx=%0d busy=%0d done=%0d, required 1 0 0 0 0",
               Direction, motor_en, step_idx, busy, done);
    end
    rst_n = 1'b1;
    exp_q.push_back(ev(10, 1'b0, 1'b1, 1));
    exp_q.push_back(ev(10, 1'b0, 1'b1, 2));
    exp_q.push_back(ev(10, 1'b0, 1'b1, 3));
`ifdef ROUTE_LOOP_EN
    exp_q.push_back(ev(10, 1'b0, 1'b1, 0));
`else
    exp_q.push_back(ev(10, 1'b1, 1'b1, 0));
`endif
    start_run();
    repeat (4) do_event();
    @(negedge clk);
    tests_run++;
`ifdef ROUTE_LOOP_EN
    if (busy !== 1'b1 || done !== 1'b0 || step_idx !== 2'd0) begin
      tests_failed++;
      $display("FAIL loop_wrap: got busy=%0d done=%0d idx=%0d, required 1 0 0", busy, done, step_idx);
    end
    do_abort();
`else
    if (busy !== 1'b0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL route_end_done: got busy=%0d done=%0d, required 0 1", busy, done);
    end
`endif
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL all_continue_events: %0d expected events left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Test sequence and final report
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; DIR = PROC;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 2'd0;
    test_reset();
    test_held_stop();
    test_glitch();
    write_cfg(2'd1, ACT_REVERSE);
    write_cfg(2'd2, ACT_PAUSE);
    write_cfg(2'd3, ACT_HALT);
    test_route();
    test_abort();
    test_cfg_lockout();
    test_all_continue();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
